// File: rtl/if_fetch_buffer_if.sv
// ============================================================================
// Module   : if_fetch_buffer_if
// Brief    : Fetch-side, instruction-memory and decode-side signal bundle
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_fetch_buffer_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCplus4F;
    logic            flushE;
    logic            stallF;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCplus4D;

    modport master (
        input  PCF, PCplus4F, flushE, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        output stallF, imem_req_valid, imem_req_addr, instr_valid,
               InstrD, PCD, PCplus4D
    );

    modport slave (
        output PCF, PCplus4F, flushE, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        input  stallF, imem_req_valid, imem_req_addr, instr_valid,
               InstrD, PCD, PCplus4D
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch_buffer.sv
// ============================================================================
// Module   : if_fetch_buffer
// Brief    : Credit-limited fetch request/response matcher feeding decode
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    if_fetch_buffer_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2*XLEN-1:0] tag_mem_q [DEPTH];
    logic [2*XLEN-1:0] tag_mem_d [DEPTH];
    logic [3*XLEN-1:0] dat_mem_q [DEPTH];
    logic [3*XLEN-1:0] dat_mem_d [DEPTH];
    logic [AW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [AW-1:0]     dat_wr_q, dat_wr_d, dat_rd_q, dat_rd_d;
    logic [CW-1:0]     tag_cnt_q, tag_cnt_d, dat_cnt_q, dat_cnt_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [CW:0]       occupancy;
    logic [CW:0]       pending;
    logic              req_valid;
    logic              req_fire;
    logic              rsp_drop;
    logic              rsp_push;
    logic              dat_pop;

    // Outstanding discards still hold a credit until their response returns.
    assign occupancy = (CW+1)'(tag_cnt_q) + (CW+1)'(discard_q) + (CW+1)'(dat_cnt_q);
    assign pending   = (CW+1)'(tag_cnt_q) + (CW+1)'(discard_q);
    assign req_valid = reset & ~bus.flushE & (occupancy < (CW+1)'(DEPTH));
    assign req_fire  = req_valid & bus.imem_req_ready;
    // Wrong-path responses always precede any tagged ones, so drain discards first.
    assign rsp_drop  = bus.imem_rsp_valid & ~bus.flushE & (discard_q != '0);
    assign rsp_push  = bus.imem_rsp_valid & ~bus.flushE & (discard_q == '0) & (tag_cnt_q != '0);
    assign dat_pop   = (dat_cnt_q != '0) & bus.instr_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = bus.PCF;
    assign bus.stallF         = reset & ~bus.flushE & ~req_fire;
    assign bus.instr_valid    = reset & (dat_cnt_q != '0);
    assign {bus.InstrD, bus.PCD, bus.PCplus4D} = reset ? dat_mem_q[dat_rd_q] : '0;

    always_comb begin
        tag_mem_d = tag_mem_q;
        dat_mem_d = dat_mem_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        dat_wr_d  = dat_wr_q;
        dat_rd_d  = dat_rd_q;
        tag_cnt_d = tag_cnt_q + CW'(req_fire) - CW'(rsp_push);
        dat_cnt_d = dat_cnt_q + CW'(rsp_push) - CW'(dat_pop);
        discard_d = discard_q;

        if (req_fire) begin
            tag_mem_d[tag_wr_q] = {bus.PCF, bus.PCplus4F};
            tag_wr_d            = tag_wr_q + AW'(1);
        end
        if (rsp_push) begin
            dat_mem_d[dat_wr_q] = {bus.imem_rsp_data, tag_mem_q[tag_rd_q]};
            dat_wr_d            = dat_wr_q + AW'(1);
            tag_rd_d            = tag_rd_q + AW'(1);
        end
        if (dat_pop) begin
            dat_rd_d = dat_rd_q + AW'(1);
        end
        if (rsp_drop) begin
            discard_d = discard_q - CW'(1);
        end

        if (bus.flushE) begin
            tag_wr_d  = '0;
            tag_rd_d  = '0;
            dat_wr_d  = '0;
            dat_rd_d  = '0;
            tag_cnt_d = '0;
            dat_cnt_d = '0;
            if (bus.imem_rsp_valid && pending != '0) begin
                discard_d = CW'(pending - (CW+1)'(1));
            end else begin
                discard_d = CW'(pending);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            dat_wr_q  <= '0;
            dat_rd_q  <= '0;
            tag_cnt_q <= '0;
            dat_cnt_q <= '0;
            discard_q <= '0;
        end else begin
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            dat_wr_q  <= dat_wr_d;
            dat_rd_q  <= dat_rd_d;
            tag_cnt_q <= tag_cnt_d;
            dat_cnt_q <= dat_cnt_d;
            discard_q <= discard_d;
        end
    end

    // Storage contents are don't-care while their slot is unoccupied.
    always_ff @(posedge clk) begin
        tag_mem_q <= tag_mem_d;
        dat_mem_q <= dat_mem_d;
    end
endmodule

`default_nettype wire

// File: tb/tb_if_fetch_buffer.sv
// ============================================================================
// Module   : tb_if_fetch_buffer
// Brief    : Randomized fetch/memory/decode environment with reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct {
        logic [31:0] pc;
        int          rdy;
        bit          live;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } dec_t;

    logic clk;
    logic reset;
    if_fetch_buffer_if #(.XLEN(XLEN)) bus ();

    if_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          t;
    int          last_rdy;
    logic [31:0] pc;
    req_t        memq[$];
    dec_t        decq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    // One cycle with reset held low; the memory is reset alongside the DUT.
    task automatic reset_cycle(input bit pulse_rsp);
        @(negedge clk);
        reset              = 1'b0;
        bus.flushE         = 1'b0;
        bus.imem_rsp_valid = pulse_rsp;
        bus.imem_rsp_data  = $urandom;
        bus.instr_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        #1;
        chk_val("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk_val("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk_val("rst_stallF", 32'(bus.stallF), 32'd0);
        chk_val("rst_InstrD", bus.InstrD, 32'd0);
        chk_val("rst_PCD", bus.PCD, 32'd0);
        memq.delete();
        decq.delete();
        pc       = 32'h0;
        last_rdy = t;
        t++;
    endtask

    task automatic step(input int p_iready, input int p_qready, input int max_lat, input int p_flush);
        bit          flush;
        bit          rsp;
        bit          exp_rv;
        bit          fire;
        logic [31:0] target;
        req_t        r;
        int          rdy;

        @(negedge clk);
        reset              = 1'b1;
        bus.instr_ready    = ($urandom_range(99) < p_iready);
        bus.imem_req_ready = ($urandom_range(99) < p_qready);
        flush              = ($urandom_range(99) < p_flush);
        target             = 32'h0000_1000 + (32'($urandom_range(255)) << 2);
        bus.flushE         = flush;
        bus.PCF            = pc;
        bus.PCplus4F       = pc + 32'd4;
        rsp                = (memq.size() > 0) && (memq[0].rdy <= t);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(memq[0].pc) : $urandom;
        exp_rv             = !flush && ((memq.size() + decq.size()) < DEPTH);
        #1;

        chk_val("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk_val("req_addr", bus.imem_req_addr, pc);
        fire = exp_rv && bus.imem_req_ready;
        chk_val("stallF", 32'(bus.stallF), 32'(!flush && !fire));
        chk_val("instr_valid", 32'(bus.instr_valid), 32'(decq.size() != 0));
        if (decq.size() != 0) begin
            chk_val("InstrD", bus.InstrD, decq[0].instr);
            chk_val("PCD", bus.PCD, decq[0].pc);
            chk_val("PCplus4D", bus.PCplus4D, decq[0].pc + 32'd4);
        end

        // A redirect kills everything in flight and everything already queued.
        if (flush) begin
            if (rsp) void'(memq.pop_front());
            foreach (memq[i]) memq[i].live = 1'b0;
            decq.delete();
            pc = target;
        end else begin
            if (decq.size() != 0 && bus.instr_ready) void'(decq.pop_front());
            if (rsp) begin
                r = memq.pop_front();
                if (r.live) decq.push_back('{instr: mem_word(r.pc), pc: r.pc});
            end
        end
        if (fire) begin
            rdy = t + $urandom_range(max_lat, 1);
            if (rdy <= last_rdy) rdy = last_rdy + 1;
            last_rdy = rdy;
            memq.push_back('{pc: pc, rdy: rdy, live: 1'b1});
            pc = pc + 32'd4;
        end
        t++;
    endtask

    task automatic run(input int n, input int p_iready, input int p_qready,
                       input int max_lat, input int p_flush);
        for (int i = 0; i < n; i++) step(p_iready, p_qready, max_lat, p_flush);
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        t                  = 0;
        last_rdy           = 0;
        pc                 = 32'h0;
        reset              = 1'b0;
        bus.PCF            = 32'h0;
        bus.PCplus4F       = 32'h4;
        bus.flushE         = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b1;

        for (int i = 0; i < 3; i++) reset_cycle(i != 1);

        run(30, 100, 100, 1, 0);    // streaming, 1-cycle memory
        run(12, 0, 100, 1, 0);      // decode stalled: fill to capacity
        run(20, 100, 100, 1, 0);    // drain in order, fetch resumes
        run(60, 100, 100, 2, 6);    // 2-cycle memory with redirects
        run(40, 80, 30, 2, 0);      // memory back-pressure
        run(1500, 70, 70, 3, 8);    // mixed random traffic

        reset_cycle(1'b1);
        reset_cycle(1'b0);
        run(600, 60, 80, 3, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
